mitll_dff_checker: RTL and testbench
====================================

Name: mitll_dff_checker

Overview:
- Clocked response checker for the SFQ D flip-flop cell (set, reset, out).
- The bench's stimulus side drives the cell. This block watches the same toggle-encoded set/reset lines and the cell's out line.
- It runs a reference model of the DFF's state machine and flags illegal stimulus, missing output pulses and spurious output pulses.
- It counts output pulses and errors for end-of-run reporting.

Parameters:
- SYNC_STAGES, 2, flops in each input synchronizer (min 2).
- WINDOW, 8, max clk cycles from detected reset event to detected out event, inclusive.
- CNT_W, 16, width of pulse and error counters.

Ports:
- clk  in  1  sampling clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- set_tgl  in  1  set stimulus; every transition is one SFQ set pulse.
- reset_tgl  in  1  reset (readout) stimulus; every transition is one pulse.
- out_tgl  in  1  DUT output; every transition is one output pulse.
- state  out  1  model state: 0 = empty, 1 = stored.
- pending  out  1  output pulse expected, window open.
- err_illegal  out  1  one-cycle strobe: set event while state=1.
- err_missing  out  1  one-cycle strobe: window expired without out.
- err_spurious  out  1  one-cycle strobe: out event with no pending.
- out_count  out  CNT_W  accepted (expected) out events.
- err_count  out  CNT_W  total error strobes.

Behaviour:
- Reset values: state=0, pending=0, all strobes 0, both counters 0. Synchronizer flops and edge-detect history are cleared to 0.
- After reset, the first sample is the reference level; no event is generated from it.
- Edge detection: event = sync_last XOR sync_prev on each line.
  - Latency from input toggle to event is SYNC_STAGES+1 cycles.
  - All three lines use identical paths, so relative order is preserved.
- Model FSM, evaluated once per cycle on that cycle's events. Order: reset event first, then set event, then out event.
  - S0 + reset: stay S0; no out expected.
  - S1 + reset: go S0; pending=1; window timer=WINDOW.
  - S0 + set: go S1.
  - S1 + set: stay S1; err_illegal strobe. The cell's error state produces no out pulse.
  - Same-cycle reset and set in S1: readout, then store. End state S1, pending=1, no error.
- Window handling:
  - Timer decrements while pending.
  - An out event with pending=1 and timer≥0 (inclusive of the expiry cycle) clears pending and increments out_count.
  - If the timer reaches 0 with no out event, pending clears and err_missing strobes in the next cycle.
  - A new S1+reset while pending=1 strobes err_missing for the old expectation and restarts the timer.
- An out event with pending=0 strobes err_spurious; out_count is not incremented.
- Strobes are registered, 1-cycle wide. Two or more in one cycle add their total to err_count.
- Counters saturate at all-ones and do not wrap.
- rst mid-operation discards pending expectations and emits no strobe.

Optional Feature:
- Macro: MITLL_DFF_CHK_FIRST_ERR_EN.
- With the macro, add outputs first_err_valid (1), first_err_code (2) and first_err_cycle (CNT_W).
  - Codes: 1=illegal, 2=missing, 3=spurious.
  - On the first error after reset, capture the code and a free-running cycle counter (saturating).
  - These hold until rst.
  - With simultaneous first errors, the lowest code wins.
- Without the macro, these ports and the cycle counter do not exist. All other behaviour is identical.

Decomposition:
- Package mitll_dff_chk_pkg holds:
  - state encoding constants ST_EMPTY=0, ST_STORED=1;
  - error code constants ERR_NONE/ERR_ILLEGAL/ERR_MISSING/ERR_SPURIOUS;
  - a saturating-increment function.
- One sub-module, tgl_edge_det: SYNC_STAGES synchronizer plus XOR edge detect. It is instantiated three times.

Test Plan:
- Reset, then set toggle at cycle 10, reset toggle at 20, out toggle at 24. Expect out_count=1, err_count=0, state=0, pending low after the out event.
- Set at 10, second set at 15. Expect err_illegal strobe exactly SYNC_STAGES+1 cycles after 15, err_count=1, state stays 1, no pending.
- Set, then reset, with no out toggle. Expect err_missing strobe WINDOW+1 cycles after the reset event, err_count=1, out_count=0.
- Out toggle with no prior set/reset. Expect err_spurious, err_count=1. A reset in state 0 followed by an out toggle also gives err_spurious.
- Set and reset toggled in the same cycle while state=1. Expect no error, state=1, pending=1; an out within WINDOW gives out_count+1.
- Illegal set, then a missing out. With MITLL_DFF_CHK_FIRST_ERR_EN: first_err_code=1 and the cycle of the first strobe. Assert rst mid-window: all outputs return to reset values with no strobe.

Source files
------------

// File: rtl/mitll_dff_chk_pkg.sv
// mitll_dff_chk_pkg: shared encodings and helpers for the SFQ DFF response checker.
// Contents: model state encoding, error code encoding, saturating add.
// Used by: mitll_dff_checker (and its optional first-error capture logic).
package mitll_dff_chk_pkg;

  // Reference-model state of the DFF cell.
  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_STORED = 1'b1
  } dff_st_e;

  // Error codes; the numeric order is also the priority order (lowest wins).
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ILLEGAL  = 2'd1,
    ERR_MISSING  = 2'd2,
    ERR_SPURIOUS = 2'd3
  } err_code_e;

  // Saturating add on 32-bit containers. Callers zero-extend narrower
  // counters and pass their all-ones value as max_val (counter width < 32).
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_val}) begin
      sat_add = max_val;
    end else begin
      sat_add = sum[31:0];
    end
  endfunction

endpackage

// File: rtl/tgl_edge_det.sv
// tgl_edge_det: synchronizes one toggle-encoded line and emits a one-cycle
// event for every level change.
// Ports: clk, rst (sync, active-high), tgl (async toggle line in),
//        evt (registered event strobe out).
// Latency from a toggle to evt is SYNC_STAGES+1 cycles. The first sample
// after rst is only a reference level and never produces an event.
module tgl_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tgl,
  output logic evt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  // vld_q[i] marks sync_q[i] as holding a real post-reset sample;
  // vld_q[SYNC_STAGES] does the same for prev_q. Comparing against a
  // cleared prev_q would otherwise fake an event when the line idles high.
  logic [SYNC_STAGES:0]   vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      vld_q  <= '0;
      evt    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tgl};
      prev_q <= sync_q[SYNC_STAGES-1];
      vld_q  <= {vld_q[SYNC_STAGES-1:0], 1'b1};
      evt    <= vld_q[SYNC_STAGES] & (sync_q[SYNC_STAGES-1] ^ prev_q);
    end
  end

endmodule

// File: rtl/mitll_dff_checker.sv
// mitll_dff_checker: clocked reference model and response checker for an SFQ
// D flip-flop cell driven by toggle-encoded set/reset lines.
// Inputs : clk, rst (sync, active-high), set_tgl, reset_tgl, out_tgl.
// Outputs: state, pending, err_illegal/err_missing/err_spurious (1-cycle
//          strobes), out_count, err_count (saturating counters).
// Optional: define MITLL_DFF_CHK_FIRST_ERR_EN to add first_err_valid,
//          first_err_code and first_err_cycle (first error after rst).
module mitll_dff_checker
  import mitll_dff_chk_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WINDOW      = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_tgl,
  input  logic             reset_tgl,
  input  logic             out_tgl,
  output logic             state,
  output logic             pending,
  output logic             err_illegal,
  output logic             err_missing,
  output logic             err_spurious,
  output logic [CNT_W-1:0] out_count,
  output logic [CNT_W-1:0] err_count
`ifdef MITLL_DFF_CHK_FIRST_ERR_EN
  ,
  output logic             first_err_valid,
  output logic [1:0]       first_err_code,
  output logic [CNT_W-1:0] first_err_cycle
`endif
);

  // Timer holds the number of cycles still allowed after the current one;
  // the cycle in which it reads zero is the last cycle an out is accepted.
  localparam int              TMR_W    = $clog2(WINDOW + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(WINDOW - 1);
  localparam logic [31:0]     CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);

  // ---------------------------------------------------------------------
  // Event detection: identical paths keep the relative order of events.
  // ---------------------------------------------------------------------
  logic set_evt;
  logic rst_evt;
  logic out_evt;

  tgl_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_set_det (
    .clk (clk),
    .rst (rst),
    .tgl (set_tgl),
    .evt (set_evt)
  );

  tgl_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_reset_det (
    .clk (clk),
    .rst (rst),
    .tgl (reset_tgl),
    .evt (rst_evt)
  );

  tgl_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_out_det (
    .clk (clk),
    .rst (rst),
    .tgl (out_tgl),
    .evt (out_evt)
  );

  // ---------------------------------------------------------------------
  // Model state
  // ---------------------------------------------------------------------
  dff_st_e          st_q,      st_d;
  logic             pend_q,    pend_d;
  logic [TMR_W-1:0] tmr_q,     tmr_d;
  logic             ill_q,     ill_d;
  logic             miss_q,    miss_d;
  logic             spur_q,    spur_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             readout;
  logic             accept;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= ST_EMPTY;
      pend_q    <= 1'b0;
      tmr_q     <= '0;
      ill_q     <= 1'b0;
      miss_q    <= 1'b0;
      spur_q    <= 1'b0;
      out_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      st_q      <= st_d;
      pend_q    <= pend_d;
      tmr_q     <= tmr_d;
      ill_q     <= ill_d;
      miss_q    <= miss_d;
      spur_q    <= spur_d;
      out_cnt_q <= out_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Next-state logic. Events of one cycle are applied in the order
  // reset, set, out, so a same-cycle reset+set in ST_STORED reads out the
  // stored bit and then stores the new one.
  always_comb begin
    st_d    = st_q;
    pend_d  = pend_q;
    tmr_d   = tmr_q;
    ill_d   = 1'b0;
    miss_d  = 1'b0;
    spur_d  = 1'b0;
    accept  = 1'b0;
    readout = rst_evt && (st_q == ST_STORED);

    // Readout: a still-open window is abandoned as missing and restarted.
    if (readout) begin
      miss_d = pend_q;
      st_d   = ST_EMPTY;
      pend_d = 1'b1;
      tmr_d  = TMR_LOAD;
    end

    // A set while storing drives the cell into its error state, which
    // never emits an out pulse, so no expectation is created.
    if (set_evt) begin
      if (st_d == ST_STORED) begin
        ill_d = 1'b1;
      end else begin
        st_d = ST_STORED;
      end
    end

    if (out_evt) begin
      if (pend_d) begin
        pend_d = 1'b0;
        accept = 1'b1;
      end else begin
        spur_d = 1'b1;
      end
    end else if (pend_q && !readout) begin
      // Window ticking; the zero cycle is the last one still accepted.
      if (tmr_q == '0) begin
        pend_d = 1'b0;
        miss_d = 1'b1;
      end else begin
        tmr_d = tmr_q - TMR_W'(1);
      end
    end

    out_cnt_d = accept ? CNT_W'(sat_add(32'(out_cnt_q), 32'd1, CNT_MAX))
                       : out_cnt_q;
    err_cnt_d = CNT_W'(sat_add(32'(err_cnt_q),
                               32'(ill_d) + 32'(miss_d) + 32'(spur_d),
                               CNT_MAX));
  end

  // Output drive
  always_comb begin
    state        = st_q;
    pending      = pend_q;
    err_illegal  = ill_q;
    err_missing  = miss_q;
    err_spurious = spur_q;
    out_count    = out_cnt_q;
    err_count    = err_cnt_q;
  end

`ifdef MITLL_DFF_CHK_FIRST_ERR_EN
  // ---------------------------------------------------------------------
  // First-error capture: records the code of the first strobe after rst
  // and the cycle-counter value during the cycle that strobe is visible.
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] cyc_q;
  logic             fe_vld_q;
  err_code_e        fe_code_q;
  logic [CNT_W-1:0] fe_cyc_q;
  err_code_e        code_now;

  // Lowest code wins when several strobes coincide.
  always_comb begin
    if (ill_q) begin
      code_now = ERR_ILLEGAL;
    end else if (miss_q) begin
      code_now = ERR_MISSING;
    end else if (spur_q) begin
      code_now = ERR_SPURIOUS;
    end else begin
      code_now = ERR_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q     <= '0;
      fe_vld_q  <= 1'b0;
      fe_code_q <= ERR_NONE;
      fe_cyc_q  <= '0;
    end else begin
      cyc_q <= CNT_W'(sat_add(32'(cyc_q), 32'd1, CNT_MAX));
      if (!fe_vld_q && (code_now != ERR_NONE)) begin
        fe_vld_q  <= 1'b1;
        fe_code_q <= code_now;
        fe_cyc_q  <= cyc_q;
      end
    end
  end

  always_comb begin
    first_err_valid = fe_vld_q;
    first_err_code  = fe_code_q;
    first_err_cycle = fe_cyc_q;
  end
`endif

endmodule

// File: tb/tb_mitll_dff_checker.sv
// tb_mitll_dff_checker: self-checking bench for mitll_dff_checker.
// Scenario tasks drive toggles one cycle at a time and compare the DUT
// against an event-level model (absolute deadlines, sample history).
module tb_mitll_dff_checker;

  localparam int S    = 2;
  localparam int W    = 8;
  localparam int CW   = 8;
  localparam int HL   = S + 3;
  localparam int MAXC = (1 << CW) - 1;
  localparam int VW   = 5 + 2 * CW;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          set_tgl   = 1'b0;
  logic          reset_tgl = 1'b0;
  logic          out_tgl   = 1'b0;
  logic          state;
  logic          pending;
  logic          err_illegal;
  logic          err_missing;
  logic          err_spurious;
  logic [CW-1:0] out_count;
  logic [CW-1:0] err_count;
`ifdef MITLL_DFF_CHK_FIRST_ERR_EN
  logic          first_err_valid;
  logic [1:0]    first_err_code;
  logic [CW-1:0] first_err_cycle;
`endif

  always #5 clk = ~clk;

  mitll_dff_checker #(.SYNC_STAGES(S), .WINDOW(W), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .set_tgl      (set_tgl),
    .reset_tgl    (reset_tgl),
    .out_tgl      (out_tgl),
    .state        (state),
    .pending      (pending),
    .err_illegal  (err_illegal),
    .err_missing  (err_missing),
    .err_spurious (err_spurious),
    .out_count    (out_count),
    .err_count    (err_count)
`ifdef MITLL_DFF_CHK_FIRST_ERR_EN
    ,
    .first_err_valid (first_err_valid),
    .first_err_code  (first_err_code),
    .first_err_cycle (first_err_cycle)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model: sampled line history, edges since rst, absolute window deadline.
  bit hs[HL];
  bit hr[HL];
  bit ho[HL];
  int since   = 0;
  int edge_no = 0;
  bit m_st, m_pend, m_ill, m_miss, m_spur;
  int m_dl, m_oc, m_ec;

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {state, pending, err_illegal, err_missing, err_spurious, out_count, err_count};
  endfunction

  function automatic logic [VW-1:0] mdl_vec();
    return {m_st, m_pend, m_ill, m_miss, m_spur, CW'(m_oc), CW'(m_ec)};
  endfunction

  // One clock: apply toggles/rst, let the DUT sample, advance the model,
  // return at the following negedge where outputs are stable.
  task automatic tick(input bit ds, input bit dr, input bit dout, input bit drst);
    bit re, se, oe;
    set_tgl   = set_tgl ^ ds;
    reset_tgl = reset_tgl ^ dr;
    out_tgl   = out_tgl ^ dout;
    rst       = drst;
    @(posedge clk);
    edge_no++;
    for (int i = HL - 1; i > 0; i--) begin
      hs[i] = hs[i-1];
      hr[i] = hr[i-1];
      ho[i] = ho[i-1];
    end
    hs[0] = set_tgl;
    hr[0] = reset_tgl;
    ho[0] = out_tgl;
    m_ill  = 1'b0;
    m_miss = 1'b0;
    m_spur = 1'b0;
    if (drst) begin
      since  = 0;
      m_st   = 1'b0;
      m_pend = 1'b0;
      m_oc   = 0;
      m_ec   = 0;
    end else begin
      since++;
      // A line change sampled S+1 edges ago is acted on now, provided the
      // older sample of the pair was taken after rst released.
      re = (since >= S + 3) && (hr[S+1] != hr[S+2]);
      se = (since >= S + 3) && (hs[S+1] != hs[S+2]);
      oe = (since >= S + 3) && (ho[S+1] != ho[S+2]);
      if (re && m_st) begin
        m_miss = m_pend;
        m_st   = 1'b0;
        m_pend = 1'b1;
        m_dl   = edge_no + W;
      end
      if (se) begin
        if (m_st) m_ill = 1'b1;
        else m_st = 1'b1;
      end
      if (oe && m_pend) begin
        m_pend = 1'b0;
        m_oc   = sat(m_oc + 1);
      end else if (oe) begin
        m_spur = 1'b1;
      end else if (m_pend && edge_no >= m_dl) begin
        m_pend = 1'b0;
        m_miss = 1'b1;
      end
      m_ec = sat(m_ec + int'(m_ill) + int'(m_miss) + int'(m_spur));
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    n_vec++;
    if (dut_vec() !== {VW{1'b0}}) begin
      n_bad++;
      $display("FAIL reset_values got=%h want=0", dut_vec());
    end
    for (int c = 0; c < 8; c++) begin
      tick(0, 0, 0, 0);
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL reset_idle c=%0d got=%h want=%h", c, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_basic();
    tick(0, 0, 0, 1);
    for (int c = 0; c < 40; c++) begin
      tick(c == 10, c == 20, c == 24, 0);
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL basic c=%0d got=%h want=%h", c, dut_vec(), mdl_vec());
      end
    end
    n_vec++;
    if (out_count !== CW'(1) || err_count !== CW'(0) || state !== 1'b0 || pending !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_final oc=%0d ec=%0d st=%b pd=%b want 1 0 0 0",
               out_count, err_count, state, pending);
    end
  endtask

  task automatic test_window_edge();
    tick(0, 0, 0, 1);
    for (int c = 0; c < 70; c++) begin
      // Out exactly WINDOW after the first readout, then WINDOW+1 after the second.
      tick(c == 5 || c == 30, c == 10 || c == 35, c == 10 + W || c == 35 + W + 1, 0);
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL window_edge c=%0d got=%h want=%h", c, dut_vec(), mdl_vec());
      end
    end
    n_vec++;
    if (out_count !== CW'(1) || err_count !== CW'(2)) begin
      n_bad++;
      $display("FAIL window_edge_final oc=%0d ec=%0d want 1 2", out_count, err_count);
    end
  endtask

  task automatic test_illegal();
    int seen = -1;
    int hits = 0;
    tick(0, 0, 0, 1);
    for (int c = 0; c < 40; c++) begin
      tick(c == 10 || c == 15, 0, 0, 0);
      if (err_illegal === 1'b1) begin
        hits++;
        if (seen < 0) seen = c;
      end
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL illegal c=%0d got=%h want=%h", c, dut_vec(), mdl_vec());
      end
    end
    n_vec++;
    if (seen != 15 + S + 1 || hits != 1 || err_count !== CW'(1) || state !== 1'b1 || pending !== 1'b0) begin
      n_bad++;
      $display("FAIL illegal_final at=%0d hits=%0d ec=%0d st=%b pd=%b want %0d 1 1 1 0",
               seen, hits, err_count, state, pending, 15 + S + 1);
    end
  endtask

  task automatic test_missing();
    int seen = -1;
    tick(0, 0, 0, 1);
    for (int c = 0; c < 40; c++) begin
      tick(c == 5, c == 10, 0, 0);
      if (err_missing === 1'b1 && seen < 0) seen = c;
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL missing c=%0d got=%h want=%h", c, dut_vec(), mdl_vec());
      end
    end
    n_vec++;
    if (seen != 10 + S + 1 + W || err_count !== CW'(1) || out_count !== CW'(0)) begin
      n_bad++;
      $display("FAIL missing_final at=%0d ec=%0d oc=%0d want %0d 1 0",
               seen, err_count, out_count, 10 + S + 1 + W);
    end
  endtask

  task automatic test_spurious();
    int seen = -1;
    tick(0, 0, 0, 1);
    for (int c = 0; c < 35; c++) begin
      tick(0, c == 12, c == 5 || c == 20, 0);
      if (err_spurious === 1'b1 && seen < 0) seen = c;
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL spurious c=%0d got=%h want=%h", c, dut_vec(), mdl_vec());
      end
    end
    n_vec++;
    if (seen != 5 + S + 1 || err_count !== CW'(2) || out_count !== CW'(0)) begin
      n_bad++;
      $display("FAIL spurious_final at=%0d ec=%0d oc=%0d want %0d 2 0",
               seen, err_count, out_count, 5 + S + 1);
    end
  endtask

  task automatic test_same_cycle();
    tick(0, 0, 0, 1);
    for (int c = 0; c < 40; c++) begin
      tick(c == 5 || c == 15, c == 15, c == 20, 0);
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL same_cycle c=%0d got=%h want=%h", c, dut_vec(), mdl_vec());
      end
      if (c == 15 + S + 1) begin
        n_vec++;
        if (state !== 1'b1 || pending !== 1'b1 || err_count !== CW'(0)) begin
          n_bad++;
          $display("FAIL same_cycle_mid st=%b pd=%b ec=%0d want 1 1 0", state, pending, err_count);
        end
      end
    end
    n_vec++;
    if (out_count !== CW'(1) || err_count !== CW'(0) || state !== 1'b1) begin
      n_bad++;
      $display("FAIL same_cycle_final oc=%0d ec=%0d st=%b want 1 0 1", out_count, err_count, state);
    end
  endtask

  task automatic test_rst_mid();
    int strobes = 0;
    tick(0, 0, 0, 1);
    for (int c = 0; c < 40; c++) begin
      tick(c == 5, c == 10, 0, c == 15);
      if (c >= 15 && (err_illegal | err_missing | err_spurious) === 1'b1) strobes++;
      if (c == 15) begin
        n_vec++;
        if (dut_vec() !== {VW{1'b0}}) begin
          n_bad++;
          $display("FAIL rst_mid_values got=%h want=0", dut_vec());
        end
      end
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL rst_mid c=%0d got=%h want=%h", c, dut_vec(), mdl_vec());
      end
    end
    n_vec++;
    if (strobes != 0 || err_count !== CW'(0)) begin
      n_bad++;
      $display("FAIL rst_mid_quiet strobes=%0d ec=%0d want 0 0", strobes, err_count);
    end
  endtask

  task automatic test_saturate();
    tick(0, 0, 0, 1);
    for (int c = 0; c < MAXC + 40; c++) begin
      tick(0, 0, 1, 0);
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL saturate c=%0d got=%h want=%h", c, dut_vec(), mdl_vec());
      end
    end
    n_vec++;
    if (err_count !== CW'(MAXC)) begin
      n_bad++;
      $display("FAIL saturate_final ec=%0d want %0d", err_count, MAXC);
    end
  endtask

  task automatic test_random();
    tick(0, 0, 0, 1);
    for (int c = 0; c < 3000; c++) begin
      tick($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 399) == 0);
      n_vec++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL random c=%0d got=%h want=%h", c, dut_vec(), mdl_vec());
      end
    end
  endtask

`ifdef MITLL_DFF_CHK_FIRST_ERR_EN
  task automatic test_first_err();
    tick(0, 0, 0, 1);
    for (int c = 0; c < 45; c++) begin
      tick(c == 5 || c == 10, c == 20, 0, 0);
    end
    // Illegal strobe is visible after the edge of c=10+S+1, i.e. S+13 edges
    // after rst, while the cycle counter reads one less.
    n_vec++;
    if (first_err_valid !== 1'b1 || first_err_code !== 2'd1 || first_err_cycle !== CW'(S + 12)
        || err_count !== CW'(2)) begin
      n_bad++;
      $display("FAIL first_err v=%b code=%0d cyc=%0d ec=%0d want 1 1 %0d 2",
               first_err_valid, first_err_code, first_err_cycle, err_count, S + 12);
    end
    tick(0, 0, 0, 1);
    n_vec++;
    if (first_err_valid !== 1'b0 || first_err_code !== 2'd0 || first_err_cycle !== CW'(0)) begin
      n_bad++;
      $display("FAIL first_err_rst v=%b code=%0d cyc=%0d want 0 0 0",
               first_err_valid, first_err_code, first_err_cycle);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_window_edge();
    test_illegal();
    test_missing();
    test_spurious();
    test_same_cycle();
    test_rst_mid();
    test_saturate();
    test_random();
`ifdef MITLL_DFF_CHK_FIRST_ERR_EN
    test_first_err();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
